// File: rtl/sweep_pkg.sv
// Shared types and constants for the truth-table sweeper: FSM states, combination count helper
// and the reference vector of the (x'+y)'.z function.
package sweep_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } state_t;

    localparam int N_IN_DEFAULT = 3;
    localparam int WAIT_W       = 4;

    function automatic int combos(input int n_in);
        return 1 << n_in;
    endfunction

    localparam int COMBOS = combos(N_IN_DEFAULT);

    // Bit 5 only: x=1, y=0, z=1 is the single minterm of (x'+y)'.z
    localparam logic [7:0] FXYZ_TT = 8'h20;

endpackage

// File: rtl/sweep_settle_timer.sv
// Settle counter: cleared by load, counts while enabled, flags expire on the last settle cycle.
module sweep_settle_timer
    import sweep_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic expire
);

    logic [WAIT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (reset || load) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= count_reg + WAIT_W'(1);
        end
    end

    assign expire = (count_reg == WAIT_W'(SETTLE - 1));

endmodule

// File: rtl/truth_table_sweeper.sv
// Walks xyz through every input combination, holds each for SETTLE cycles, then captures s
// into the truth vector and keeps a running count of ones.
module truth_table_sweeper
    import sweep_pkg::*;
#(
    parameter int N_IN   = 3,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 s,
    output logic [N_IN-1:0]      xyz,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   tt,
    output logic [N_IN:0]        ones
);

    localparam int NC = combos(N_IN);

    state_t state_reg;
    logic   timer_load;
    logic   timer_en;
    logic   settle_expire;

    // Restart the settle count whenever a new combination is put on xyz
    assign timer_load = ((state_reg == IDLE) && start) || (state_reg == SAMPLE);
    assign timer_en   = (state_reg == DRIVE);

    sweep_settle_timer #(
        .SETTLE (SETTLE)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (timer_load),
        .en     (timer_en),
        .expire (settle_expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            xyz       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            tt        <= '0;
            ones      <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        xyz       <= '0;
                        tt        <= '0;
                        ones      <= '0;
                        busy      <= 1'b1;
                        state_reg <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (settle_expire) begin
                        state_reg <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    tt[xyz] <= s;
                    ones    <= ones + {{N_IN{1'b0}}, s};
                    // Terminal compare precedes the increment, so xyz never wraps
                    if (xyz == N_IN'(NC - 1)) begin
                        xyz       <= '0;
                        done      <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        xyz       <= xyz + N_IN'(1);
                        state_reg <= DRIVE;
                    end
                end
                DONE: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
